// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: bus-mapped multiplexed seven-segment controller with hex decode,
// per-digit blanking, decimal points, leading-zero suppression and anti-ghost blanking.
module seg_scan_ctrl #(
    parameter int          DIGITS    = 4,
    parameter int          SCAN_DIV  = 50000,
    parameter int          BLANK_CYC = 16,
    parameter logic [31:0] ADDR_BASE = 32'h4000_0010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       rd_data,
    output logic [6:0]        seg_out,
    output logic              dp_out,
    output logic [DIGITS-1:0] an_out
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [VW-1:0]     value_q, value_d, hi_nibs;
    logic              en_q, en_d, lzs_q, lzs_d;
    logic [DIGITS-1:0] blank_q, blank_d, dpm_q, dpm_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_q;
    logic              dp_q;
    logic [DIGITS-1:0] an_q;
    logic              wr_val, wr_ctl, slot_end, dark;
    logic [3:0]        nib;
    logic [31:0]       ctrl_rd;
    logic              unused_data;

    assign unused_data = ^data_in;
    assign wr_val   = we && addr == ADDR_BASE;
    assign wr_ctl   = we && addr == ADDR_BASE + 32'd4;
    assign slot_end = cnt_q == CW'(SCAN_DIV - 1);
    // Digits above idx, shifted down so nib is digit idx and the rest tests leading zeros.
    assign hi_nibs  = value_q >> {idx_q, 2'b00};
    assign nib      = hi_nibs[3:0];
    assign dark     = !en_q || cnt_q < CW'(BLANK_CYC) || blank_q[idx_q]
                      || (lzs_q && idx_q != '0 && hi_nibs == '0);

    always_comb begin
        value_d = wr_val ? data_in[VW-1:0] : value_q;
        en_d    = wr_ctl ? data_in[0] : en_q;
        lzs_d   = wr_ctl ? data_in[1] : lzs_q;
        blank_d = wr_ctl ? data_in[8 +: DIGITS] : blank_q;
        dpm_d   = wr_ctl ? data_in[16 +: DIGITS] : dpm_q;
        cnt_d   = (!en_q || slot_end) ? '0 : cnt_q + 1'b1;
        idx_d   = !en_q ? '0 : !slot_end ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
    end

    always_comb begin
        ctrl_rd              = '0;
        ctrl_rd[0]           = en_q;
        ctrl_rd[1]           = lzs_q;
        ctrl_rd[8 +: DIGITS]  = blank_q;
        ctrl_rd[16 +: DIGITS] = dpm_q;
        rd_data = addr == ADDR_BASE ? 32'(value_q) : addr == ADDR_BASE + 32'd4 ? ctrl_rd : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
            en_q    <= 1'b1;
            lzs_q   <= 1'b0;
            blank_q <= '0;
            dpm_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            an_q    <= '1;
        end else begin
            value_q <= value_d;
            en_q    <= en_d;
            lzs_q   <= lzs_d;
            blank_q <= blank_d;
            dpm_q   <= dpm_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= dark ? 7'h7F : HEX[nib];
            dp_q    <= dark | ~dpm_q[idx_q];
            an_q    <= dark ? '1 : ~(DIGITS'(1) << idx_q);
        end
    end

    assign seg_out = seg_q;
    assign dp_out  = dp_q;
    assign an_out  = an_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and randomized bus traffic against a slot/phase arithmetic model.
module tb_seg_scan_ctrl;
    localparam int          D     = 4;
    localparam int          SD    = 8;
    localparam int          BC    = 2;
    localparam logic [31:0] BASE  = 32'h4000_0010;
    localparam logic [31:0] CMASK = 32'h000F_0F03;
    localparam logic [6:0]  SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic          clk = 1'b0;
    logic          rst_n;
    logic          we = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   data_in = '0;
    logic [31:0]   rd_data;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic [D-1:0]  an_out;
    int            checks = 0;
    int            errors = 0;
    logic [31:0]   m_value, m_ctrl;
    int            m_k;
    logic [6:0]    e_seg;
    logic          e_dp;
    logic [D-1:0]  e_an;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC), .ADDR_BASE(BASE)) dut (
        .clk(clk), .rst(rst_n), .we(we), .addr(addr), .data_in(data_in),
        .rd_data(rd_data), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // k counts enabled cycles since scanning (re)started; slot and phase follow by division.
    function automatic logic [D+7:0] expect_pins(input logic [31:0] v, input logic [31:0] c, input int k);
        int slot;
        int phase;
        logic [3:0] n;
        logic lit;
        slot  = (k / SD) % D;
        phase = k % SD;
        n     = 4'(v >> (4 * slot));
        lit   = c[0] && phase >= BC && !c[8 + slot] && !(c[1] && slot != 0 && (v >> (4 * slot)) == 0);
        return lit ? {~(4'b0001 << slot), SEG_TAB[n], ~c[16 + slot]} : {4'hF, 7'h7F, 1'b1};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_value <= '0;
            m_ctrl  <= 32'h1;
            m_k     <= 0;
            e_seg   <= 7'h7F;
            e_dp    <= 1'b1;
            e_an    <= '1;
        end else begin
            {e_an, e_seg, e_dp} <= expect_pins(m_value, m_ctrl, m_k);
            m_k <= m_ctrl[0] ? m_k + 1 : 0;
            if (we && addr == BASE) m_value <= data_in & 32'h0000_FFFF;
            if (we && addr == BASE + 32'd4) m_ctrl <= data_in & CMASK;
        end
    end

    always @(negedge clk) begin
        check("an", 32'(an_out), 32'(e_an));
        check("seg", 32'(seg_out), 32'(e_seg));
        check("dp", 32'(dp_out), 32'(e_dp));
        check("rd", rd_data, addr == BASE ? m_value : addr == BASE + 32'd4 ? m_ctrl : 32'h0);
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic w = 1'b1);
        @(negedge clk);
        #1;
        we = w;
        addr = a;
        data_in = d;
        @(negedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        wr(BASE, 32'h0000_A3F1);
        repeat (40) @(negedge clk);
        wr(BASE, 32'h0000_0012);
        wr(BASE + 32'd4, 32'h0002_0003);
        repeat (40) @(negedge clk);
        wr(BASE + 32'd4, 32'h0000_0501);
        repeat (40) @(negedge clk);
        repeat (3) @(negedge clk);
        wr(BASE + 32'd4, 32'h0);
        repeat (5) @(negedge clk);
        wr(BASE + 32'd4, 32'h1);
        repeat (20) @(negedge clk);
        wr(BASE + 32'd8, $urandom);
        wr(BASE, $urandom, 1'b0);
        wr(BASE + 32'd4, 32'h0, 1'b0);
        @(negedge clk);
        #1 addr = BASE + 32'd8;
        #1 check("rd_unmapped", rd_data, 32'h0);
        wr(BASE, 32'h0000_8888);
        repeat (13) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_an", 32'(an_out), 32'hF);
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_dp", 32'(dp_out), 32'h1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            #1;
            case ($urandom_range(0, 3))
                0: addr = BASE;
                1: addr = BASE + 32'd4;
                2: addr = BASE + 32'd8;
                default: addr = $urandom;
            endcase
            we = $urandom_range(0, 9) < 2;
            data_in = $urandom;
            if (addr == BASE) data_in = data_in >> (4 * $urandom_range(0, 4));
            if (addr == BASE + 32'd4 && $urandom_range(0, 7) != 0) data_in[0] = 1'b1;
        end
        @(negedge clk);
        #1 we = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
